// File: rtl/mux_stream_arb.sv
// N-channel valid/ready stream multiplexer with packet-atomic round-robin or forced-select
// arbitration onto one registered output slot.
module mux_stream_arb #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CH    = 4,
  parameter int unsigned SELW  = $clog2(CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode,
  input  logic [SELW-1:0]     sel_in,
  input  logic [CH*WIDTH-1:0] in_data,
  input  logic [CH-1:0]       in_valid,
  input  logic [CH-1:0]       in_last,
  output logic [CH-1:0]       in_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_valid,
  output logic                out_last,
  output logic [SELW-1:0]     out_ch,
  input  logic                out_ready
);

  typedef enum logic [0:0] {StIdle, StLock} state_e;

  state_e            state_q, state_d;
  logic [SELW-1:0]   lock_q, lock_d;
  logic [SELW-1:0]   rr_q, rr_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [SELW-1:0]   out_ch_q, out_ch_d;

  logic [SELW-1:0]   grant;
  logic              grant_vld;
  logic              adv;
  logic              xfer;

  assign adv  = !out_valid_q || out_ready;
  assign xfer = grant_vld && adv;

  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!mode) begin
          // Scan downwards so the channel closest to rr_q is the final assignment.
          for (int k = int'(CH) - 1; k >= 0; k--) begin
            if (in_valid[(int'(rr_q) + k) % int'(CH)]) begin
              grant     = SELW'((int'(rr_q) + k) % int'(CH));
              grant_vld = 1'b1;
            end
          end
        end else if (32'(sel_in) < CH) begin
          grant     = sel_in;
          grant_vld = in_valid[sel_in];
        end
      end
      StLock: begin
        grant     = lock_q;
        grant_vld = in_valid[lock_q];
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready = '0;
    if (state_q == StLock) begin
      in_ready[lock_q] = adv;
    end else if (grant_vld) begin
      in_ready[grant] = adv;
    end
  end

  always_comb begin
    state_d     = state_q;
    lock_d      = lock_q;
    rr_d        = rr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[32'(grant) * WIDTH +: WIDTH];
      out_last_d  = in_last[grant];
      out_ch_d    = grant;
      if (in_last[grant]) begin
        state_d = StIdle;
        rr_d    = SELW'((int'(grant) + 1) % int'(CH));
      end else begin
        state_d = StLock;
        lock_d  = grant;
      end
    end else if (adv) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      lock_q      <= '0;
      rr_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      lock_q      <= lock_d;
      rr_q        <= rr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_stream_arb.sv
// Randomised scoreboard bench for mux_stream_arb: a packet-level arbitration model predicts
// grants and expected output words; a separate monitor checks what leaves the output port.
module tb_mux_stream_arb;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned CH    = 4;
  localparam int unsigned SELW  = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                mode = 1'b0;
  logic [SELW-1:0]     sel_in = '0;
  logic [CH*WIDTH-1:0] in_data = '0;
  logic [CH-1:0]       in_valid = '0;
  logic [CH-1:0]       in_last = '0;
  logic [CH-1:0]       in_ready;
  logic [WIDTH-1:0]    out_data;
  logic                out_valid;
  logic                out_last;
  logic [SELW-1:0]     out_ch;
  logic                out_ready = 1'b0;

  always #5 clk = ~clk;

  mux_stream_arb #(.WIDTH(WIDTH), .CH(CH)) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .sel_in   (sel_in),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_last (out_last),
    .out_ch   (out_ch),
    .out_ready(out_ready)
  );

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } word_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
    logic [SELW-1:0]  ch;
  } exp_t;

  word_t drv_q[CH][$];
  exp_t  exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  // Reference model: packet owner (-1 = none), round-robin start, output slot occupancy.
  int m_owner = -1;
  int m_rr    = 0;
  bit m_ov    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic refill(input int c, input int maxlen);
    int len;
    if (maxlen > 0 && drv_q[c].size() == 0) begin
      len = $urandom_range(1, maxlen);
      for (int i = 0; i < len; i++) begin
        word_t w;
        w.data = $urandom;
        w.last = (i == len - 1);
        drv_q[c].push_back(w);
      end
    end
  endtask

  // One clock of stimulus; mpol: 0 round-robin, 1 forced, 2 mixed. maxlen=0 stops new packets.
  task automatic cycle(input int vpct, input int rpct, input int maxlen, input int mpol);
    logic [CH-1:0] exp_rdy;
    bit            adv;
    int            g;
    @(posedge clk);
    #1;
    if (mpol == 0) mode = 1'b0;
    else if (mpol == 1) mode = 1'b1;
    else if ($urandom_range(0, 7) == 0) mode = ~mode;
    if ($urandom_range(0, 3) == 0) sel_in = SELW'($urandom_range(0, CH - 1));
    for (int c = 0; c < int'(CH); c++) begin
      refill(c, maxlen);
      if (drv_q[c].size() > 0) begin
        in_valid[c] = ($urandom_range(0, 99) < vpct);
        in_data[c*WIDTH +: WIDTH] = drv_q[c][0].data;
        in_last[c] = drv_q[c][0].last;
      end else begin
        in_valid[c] = 1'b0;
        in_data[c*WIDTH +: WIDTH] = '0;
        in_last[c] = 1'b0;
      end
    end
    out_ready = ($urandom_range(0, 99) < rpct);

    adv     = !m_ov || out_ready;
    g       = -1;
    exp_rdy = '0;
    if (m_owner >= 0) begin
      exp_rdy[m_owner] = adv;
      if (in_valid[m_owner]) g = m_owner;
    end else if (!mode) begin
      for (int k = 0; k < int'(CH); k++) begin
        if (in_valid[(m_rr + k) % int'(CH)]) begin
          g = (m_rr + k) % int'(CH);
          break;
        end
      end
    end else if (in_valid[sel_in]) begin
      g = int'(sel_in);
    end
    if (m_owner < 0 && g >= 0) exp_rdy[g] = adv;

    @(negedge clk);
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    if (g >= 0 && adv) begin
      word_t w;
      exp_t  e;
      w = drv_q[g].pop_front();
      e.data = w.data;
      e.last = w.last;
      e.ch   = SELW'(g);
      exp_q.push_back(e);
      m_ov = 1'b1;
      if (w.last) begin
        m_owner = -1;
        m_rr    = (g + 1) % int'(CH);
      end else begin
        m_owner = g;
      end
    end else if (adv) begin
      m_ov = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < int'(CH); c++) drv_q[c].delete();
    exp_q.delete();
    m_owner = -1;
    m_rr    = 0;
    m_ov    = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_out_ch", 64'(out_ch), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks stall stability.
  initial begin
    bit               hold = 1'b0;
    logic [WIDTH-1:0] h_data;
    logic             h_last;
    logic [SELW-1:0]  h_ch;
    exp_t             e;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("stall_valid", 64'(out_valid), 64'd1);
          check("stall_data", 64'(out_data), 64'(h_data));
          check("stall_last", 64'(out_last), 64'(h_last));
          check("stall_ch", 64'(out_ch), 64'(h_ch));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL spurious_output: got ch %0d data %0h expected no word", out_ch, out_data);
          end else begin
            e = exp_q.pop_front();
            check("out_data", 64'(out_data), 64'(e.data));
            check("out_last", 64'(out_last), 64'(e.last));
            check("out_ch", 64'(out_ch), 64'(e.ch));
          end
        end
        hold   = out_valid && !out_ready;
        h_data = out_data;
        h_last = out_last;
        h_ch   = out_ch;
      end
    end
  end

  initial begin
    int budget;
    int left;
    repeat (3) @(posedge clk);
    do_reset();
    repeat (200) cycle(100, 100, 1, 0);
    repeat (300) cycle(70, 100, 4, 0);
    repeat (300) cycle(60, 50, 5, 0);
    repeat (300) cycle(80, 70, 4, 1);
    repeat (300) cycle(60, 60, 4, 2);

    // Drive until a packet is mid-flight with a word held, then reset on top of it.
    budget = 0;
    while (!(m_owner >= 0 && m_ov) && budget < 300) begin
      cycle(100, 50, 6, 0);
      budget++;
    end
    check("lock_reached", 64'(m_owner >= 0 && m_ov), 64'd1);
    do_reset();
    repeat (300) cycle(100, 100, 3, 0);
    repeat (300) cycle(70, 70, 4, 2);

    budget = 0;
    left   = 1;
    while (left != 0 && budget < 3000) begin
      cycle(100, 100, 0, 0);
      budget++;
      left = exp_q.size() + int'(m_ov);
      for (int c = 0; c < int'(CH); c++) left += drv_q[c].size();
    end
    @(negedge clk);
    check("drained", 64'(left), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
